// File: rtl/match_unit.sv
// -----------------------------------------------------------------------------
// match_unit
//
// Multi-cycle pattern-search execution unit that sits beside the EX-stage ALU.
// The PAT_W-bit pattern is searched for inside a DATA_W-bit word. LANES
// candidate bit positions are compared per search cycle. The unit returns one
// of two results, selected by mode:
//   mode 0 : lowest matching bit index, or all ones when nothing matches
//   mode 1 : number of matching positions (overlapping matches count),
//            zero-extended to DATA_W
// While an operation is in flight the unit requests a pipeline stall. A
// flush aborts the operation without producing a result.
//
// Ports:
//   clk          in   1       clock, rising edge
//   resetn       in   1       asynchronous active-low reset
//   start        in   1       operation request, sampled only while idle
//   mode         in   1       0 = first-match index, 1 = match count
//   flush        in   1       abort current operation (beats start)
//   src1         in   PAT_W   pattern (low bits of the ALU source 1)
//   src2         in   DATA_W  word to search
//   stallreq     out  1       pipeline stall request
//   result_valid out  1       one-cycle result strobe
//   result       out  DATA_W  index or count; holds until the next result
//
// Build option:
//   MATCH_EARLY_EXIT_EN - when defined, a mode-0 search finishes right after
//   the first group that contains a match. When undefined, every operation
//   takes the same number of cycles, so the stall length is deterministic.
// -----------------------------------------------------------------------------
module match_unit #(
  parameter int DATA_W = 32,
  parameter int PAT_W  = 8,
  parameter int LANES  = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              mode,
  input  logic              flush,
  input  logic [PAT_W-1:0]  src1,
  input  logic [DATA_W-1:0] src2,
  output logic              stallreq,
  output logic              result_valid,
  output logic [DATA_W-1:0] result
);

  // Number of candidate positions and number of search groups.
  localparam int NPOS   = DATA_W - PAT_W + 1;
  localparam int NCYC   = (NPOS + LANES - 1) / LANES;
  // The latched word is padded by LANES zero bits at the top. Every lane's
  // window then stays in range while the word shifts down one group per
  // cycle. Windows that reach into the padding belong to positions >= NPOS,
  // and those positions are masked off.
  localparam int EXT_W  = DATA_W + LANES;
  localparam int K_W    = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam int CNT_W  = $clog2(NPOS + 1);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int GC_W   = $clog2(LANES + 1);

  localparam logic [DATA_W-1:0] NPOS_V    = DATA_W'(NPOS);
  localparam logic [DATA_W-1:0] LANES_V   = DATA_W'(LANES);
  localparam logic [K_W-1:0]    LAST_GRP  = K_W'(NCYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t             state;
  logic [K_W-1:0]     grp;        // group counter k
  logic [DATA_W-1:0]  grp_base;   // k*LANES, kept as a running sum
  logic [PAT_W-1:0]   pat;        // latched pattern
  logic [EXT_W-1:0]   word;       // latched word, shifted down LANES per group
  logic               mode_q;     // latched mode
  logic               found;      // mode 0: a match has been recorded
  logic [DATA_W-1:0]  first_pos;  // mode 0: lowest matching position
  logic [CNT_W-1:0]   count;      // mode 1: running match count

  // ---------------------------------------------------------------------------
  // Per-group comparison. Lane gi checks absolute position grp_base+gi. The
  // word has already been shifted by grp_base, so lane gi looks at bits
  // [gi +: PAT_W] of the shifted word.
  // ---------------------------------------------------------------------------
  logic [LANES-1:0] hit;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign hit[gi] = (word[gi +: PAT_W] == pat) &&
                     ((grp_base + DATA_W'(gi)) < NPOS_V);
  end

  logic              grp_any;
  logic [LANE_W-1:0] grp_low;
  logic [GC_W-1:0]   grp_cnt;

  always_comb begin
    grp_any = |hit;
    // Scan from the top lane down, so the last assignment is the lowest hit.
    grp_low = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (hit[i]) grp_low = LANE_W'(i);
    end
    grp_cnt = '0;
    for (int i = 0; i < LANES; i++) begin
      grp_cnt = grp_cnt + GC_W'(hit[i]);
    end
  end

  // Accumulator values after this group has been folded in.
  logic              found_next;
  logic [DATA_W-1:0] first_next;
  logic [CNT_W-1:0]  count_next;
  logic              last_grp;
  logic              early_exit;

  always_comb begin
    found_next = found | grp_any;
    // Once a first match is recorded it is never overwritten.
    first_next = found ? first_pos : (grp_base + DATA_W'(grp_low));
    count_next = count + CNT_W'(grp_cnt);
    last_grp   = (grp == LAST_GRP);
  end

`ifdef MATCH_EARLY_EXIT_EN
  // A first-match search is settled by the first group that contains a hit.
  assign early_exit = ~mode_q & grp_any;
`else
  assign early_exit = 1'b0;
`endif

  // Final value loaded into result on the way into DONE.
  logic [DATA_W-1:0] result_next;

  always_comb begin
    if (mode_q) begin
      result_next = DATA_W'(count_next);
    end else if (found_next) begin
      result_next = first_next;
    end else begin
      result_next = '1;
    end
  end

  // The stall request must already be raised in the request cycle, before the
  // FSM has left IDLE. That is why the request term is combinational.
  assign stallreq = ((state == IDLE) && start && !flush) || (state == SEARCH);

  // ---------------------------------------------------------------------------
  // Control FSM with registered result outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      grp          <= '0;
      grp_base     <= '0;
      pat          <= '0;
      word         <= '0;
      mode_q       <= 1'b0;
      found        <= 1'b0;
      first_pos    <= '0;
      count        <= '0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      // The strobe is high only in the cycle that follows the final group.
      result_valid <= 1'b0;
      if (flush) begin
        // Abort: no strobe, and result keeps its previous value.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              pat       <= src1;
              word      <= {LANES'(0), src2};
              mode_q    <= mode;
              found     <= 1'b0;
              first_pos <= '0;
              count     <= '0;
              grp       <= '0;
              grp_base  <= '0;
              state     <= SEARCH;
            end
          end
          SEARCH: begin
            found     <= found_next;
            first_pos <= first_next;
            count     <= count_next;
            word      <= word >> LANES;
            grp       <= grp + K_W'(1);
            grp_base  <= grp_base + LANES_V;
            if (last_grp || early_exit) begin
              state        <= DONE;
              result_valid <= 1'b1;
              result       <= result_next;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_match_unit.sv
// -----------------------------------------------------------------------------
// tb_match_unit
//
// Self-checking bench for match_unit. The main instance uses the default
// geometry (32/8/4). Three further instances cover the geometry corners:
// LANES=1, LANES=NPOS (one group), and PAT_W=DATA_W (a single position).
// Expected results and latencies come from a position-by-position reference
// search (ref_model). Latency is counted in cycles after the start edge: the
// cycle that shows result_valid is cycle c, where c=1 is the cycle right after
// the start edge.
// -----------------------------------------------------------------------------
module tb_match_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        start;
  logic        mode;
  logic        flush;
  logic [7:0]  src1;
  logic [31:0] src2;
  logic        stallreq;
  logic        result_valid;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_hold;   // value result must currently be holding

  match_unit #(.DATA_W(32), .PAT_W(8), .LANES(4)) u_dut (
    .clk          (clk),
    .resetn       (resetn),
    .start        (start),
    .mode         (mode),
    .flush        (flush),
    .src1         (src1),
    .src2         (src2),
    .stallreq     (stallreq),
    .result_valid (result_valid),
    .result       (result)
  );

  // Geometry-corner instances, driven together during test_sweep.
  logic        sw_start;
  logic        sw_mode;
  logic [7:0]  sw_pat8;
  logic [31:0] sw_pat32;
  logic [31:0] sw_word;
  logic        sw_stall [3];
  logic        sw_valid [3];
  logic [31:0] sw_res   [3];

  match_unit #(.DATA_W(32), .PAT_W(8), .LANES(1)) u_lanes1 (
    .clk(clk), .resetn(resetn), .start(sw_start), .mode(sw_mode), .flush(flush),
    .src1(sw_pat8), .src2(sw_word), .stallreq(sw_stall[0]),
    .result_valid(sw_valid[0]), .result(sw_res[0])
  );

  match_unit #(.DATA_W(32), .PAT_W(8), .LANES(25)) u_lanes25 (
    .clk(clk), .resetn(resetn), .start(sw_start), .mode(sw_mode), .flush(flush),
    .src1(sw_pat8), .src2(sw_word), .stallreq(sw_stall[1]),
    .result_valid(sw_valid[1]), .result(sw_res[1])
  );

  match_unit #(.DATA_W(32), .PAT_W(32), .LANES(1)) u_fullpat (
    .clk(clk), .resetn(resetn), .start(sw_start), .mode(sw_mode), .flush(flush),
    .src1(sw_pat32), .src2(sw_word), .stallreq(sw_stall[2]),
    .result_valid(sw_valid[2]), .result(sw_res[2])
  );

  // Reference search: test every candidate position directly.
  function automatic void ref_model(input logic [31:0] w, input logic [31:0] p,
                                    input int pw, input int lanes, input logic m,
                                    output logic [31:0] res, output int lat);
    int npos;
    int ncyc;
    int cnt;
    int first;
    logic [31:0] mask;
    npos  = 32 - pw + 1;
    ncyc  = (npos + lanes - 1) / lanes;
    cnt   = 0;
    first = -1;
    mask  = (pw == 32) ? 32'hFFFF_FFFF : ((32'd1 << pw) - 32'd1);
    for (int q = 0; q < npos; q++) begin
      if (((w >> q) & mask) == (p & mask)) begin
        cnt++;
        if (first < 0) first = q;
      end
    end
    res = m ? 32'(cnt) : ((first < 0) ? 32'hFFFF_FFFF : 32'(first));
    lat = ncyc + 1;
`ifdef MATCH_EARLY_EXIT_EN
    if (!m && first >= 0) lat = first / lanes + 2;
`endif
  endfunction

  // Issues one operation on the main instance and observes it for 40 cycles.
  // The task is entered 1 time unit after a rising edge with the unit idle.
  // While the operation runs, the operand inputs are scrambled. When reissue
  // is set, start is raised again during the early search cycles.
  task automatic run_op(input logic [7:0] p, input logic [31:0] w, input logic m,
                        input bit reissue, output logic [31:0] res, output int lat,
                        output int nvalid, output int nstall, output logic st0);
    src1  = p;
    src2  = w;
    mode  = m;
    flush = 1'b0;
    start = 1'b1;
    #1 st0 = stallreq;
    @(posedge clk); #1;
    start  = 1'b0;
    res    = 32'hDEAD_0BAD;
    lat    = -1;
    nvalid = 0;
    nstall = 0;
    for (int c = 1; c <= 40; c++) begin
      if (stallreq) nstall++;
      if (result_valid) begin
        nvalid++;
        if (lat < 0) begin
          lat = c;
          res = result;
        end
      end
      start = reissue && (c <= 3);
      src1  = 8'($urandom);
      src2  = $urandom;
      mode  = 1'($urandom);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    resetn   = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    flush    = 1'b0;
    src1     = '0;
    src2     = '0;
    sw_start = 1'b0;
    sw_mode  = 1'b0;
    sw_pat8  = '0;
    sw_pat32 = '0;
    sw_word  = '0;
    #1;
    n_cmp++;
    if (result !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_result: got %h want %h", result, 32'd0);
    end
    n_cmp++;
    if (result_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_valid: got %b want 0", result_valid);
    end
    n_cmp++;
    if (stallreq !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_stall: got %b want 0", stallreq);
    end
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    exp_hold = 32'd0;
    $display("reset: result=%h valid=%b stall=%b", result, result_valid, stallreq);
  endtask

  task automatic test_directed;
    logic [7:0]  pv [5];
    logic [31:0] wv [5];
    logic        mv [5];
    logic [31:0] ev [5];
    logic [31:0] r, er;
    int lat, el, nv, ns;
    logic st0;
    pv = '{8'hAB, 8'hFF, 8'hFF, 8'h5A, 8'h5A};
    wv = '{32'h0000_AB00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
    mv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    ev = '{32'd8, 32'd25, 32'd0, 32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 5; i++) begin
      ref_model(wv[i], {24'd0, pv[i]}, 8, 4, mv[i], er, el);
      run_op(pv[i], wv[i], mv[i], 1'b0, r, lat, nv, ns, st0);
      $display("directed %0d: pat=%h word=%h mode=%b result=%h lat=%0d valids=%0d stalls=%0d",
               i, pv[i], wv[i], mv[i], r, lat, nv, ns);
      n_cmp++;
      if (r !== ev[i]) begin
        n_bad++;
        $display("FAIL directed_result[%0d]: got %h want %h", i, r, ev[i]);
      end
      n_cmp++;
      if (lat !== el) begin
        n_bad++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, el);
      end
      n_cmp++;
      if (nv !== 1) begin
        n_bad++;
        $display("FAIL directed_valid_count[%0d]: got %0d want 1", i, nv);
      end
      n_cmp++;
      if (ns !== el - 1) begin
        n_bad++;
        $display("FAIL directed_stall_cycles[%0d]: got %0d want %0d", i, ns, el - 1);
      end
      n_cmp++;
      if (st0 !== 1'b1) begin
        n_bad++;
        $display("FAIL directed_stall_start[%0d]: got %b want 1", i, st0);
      end
      n_cmp++;
      if (result !== ev[i]) begin
        n_bad++;
        $display("FAIL directed_hold[%0d]: got %h want %h", i, result, ev[i]);
      end
      exp_hold = ev[i];
    end
  endtask

  task automatic test_random;
    logic [7:0]  p;
    logic [31:0] w, r, er;
    logic m, st0;
    int q, lat, el, nv, ns;
    for (int i = 0; i < 20; i++) begin
      p = 8'($urandom);
      w = $urandom;
      m = 1'($urandom);
      if ($urandom_range(1, 0) == 1) begin
        q = $urandom_range(24, 0);
        w[q +: 8] = p;
      end
      ref_model(w, {24'd0, p}, 8, 4, m, er, el);
      run_op(p, w, m, 1'b0, r, lat, nv, ns, st0);
      $display("random %0d: pat=%h word=%h mode=%b result=%h lat=%0d", i, p, w, m, r, lat);
      n_cmp++;
      if (r !== er) begin
        n_bad++;
        $display("FAIL random_result[%0d]: got %h want %h", i, r, er);
      end
      n_cmp++;
      if (lat !== el || nv !== 1) begin
        n_bad++;
        $display("FAIL random_timing[%0d]: got lat=%0d valids=%0d want lat=%0d valids=1",
                 i, lat, nv, el);
      end
      exp_hold = er;
    end
  endtask

  task automatic test_flush;
    int nv, ns, lat, el;
    logic [31:0] r, er;
    logic st0;
    // Abort on the third search cycle.
    src1  = 8'hFF;
    src2  = 32'hFFFF_FFFF;
    mode  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    $display("flush mid-search: stall=%b valid=%b result=%h", stallreq, result_valid, result);
    n_cmp++;
    if (stallreq !== 1'b0 || result_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_idle: got stall=%b valid=%b want 0/0", stallreq, result_valid);
    end
    n_cmp++;
    if (result !== exp_hold) begin
      n_bad++;
      $display("FAIL flush_hold: got %h want %h", result, exp_hold);
    end
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      if (result_valid) nv++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (nv !== 0) begin
      n_bad++;
      $display("FAIL flush_no_valid: got %0d strobes want 0", nv);
    end
    // A fresh operation after the abort completes normally.
    ref_model(32'h0000_AB00, 32'h0000_00AB, 8, 4, 1'b0, er, el);
    run_op(8'hAB, 32'h0000_AB00, 1'b0, 1'b0, r, lat, nv, ns, st0);
    $display("after flush: result=%h lat=%0d valids=%0d", r, lat, nv);
    n_cmp++;
    if (r !== er || lat !== el || nv !== 1) begin
      n_bad++;
      $display("FAIL flush_restart: got %h lat=%0d valids=%0d want %h lat=%0d valids=1",
               r, lat, nv, er, el);
    end
    exp_hold = er;
    // flush and start in the same idle cycle: the request is dropped.
    src1  = 8'h00;
    src2  = 32'h0;
    mode  = 1'b1;
    start = 1'b1;
    flush = 1'b1;
    #1;
    n_cmp++;
    if (stallreq !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_start_stall: got %b want 0", stallreq);
    end
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b0;
    nv = 0;
    ns = 0;
    for (int c = 0; c < 12; c++) begin
      if (result_valid) nv++;
      if (stallreq) ns++;
      @(posedge clk); #1;
    end
    $display("flush+start: strobes=%0d stall_cycles=%0d", nv, ns);
    n_cmp++;
    if (nv !== 0 || ns !== 0) begin
      n_bad++;
      $display("FAIL flush_start_idle: got strobes=%0d stalls=%0d want 0/0", nv, ns);
    end
  endtask

  task automatic test_async_reset;
    int nv;
    src1  = 8'hFF;
    src2  = 32'hFFFF_FFFF;
    mode  = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    $display("async reset: result=%h valid=%b stall=%b", result, result_valid, stallreq);
    n_cmp++;
    if (result !== 32'd0 || result_valid !== 1'b0 || stallreq !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got result=%h valid=%b stall=%b want 0/0/0",
               result, result_valid, stallreq);
    end
    @(posedge clk);
    #3 resetn = 1'b1;
    @(posedge clk); #1;
    nv = 0;
    for (int c = 0; c < 15; c++) begin
      if (result_valid) nv++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (nv !== 0 || result !== 32'd0) begin
      n_bad++;
      $display("FAIL async_reset_after: got strobes=%0d result=%h want 0/0", nv, result);
    end
    exp_hold = 32'd0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] r, er, w;
    logic [7:0] p;
    logic st0;
    int lat, el, nv, ns;
    // start is raised again while busy, and the requests must be ignored.
    p = 8'h3C;
    w = 32'h3C3C_F03C;
    ref_model(w, {24'd0, p}, 8, 4, 1'b1, er, el);
    run_op(p, w, 1'b1, 1'b1, r, lat, nv, ns, st0);
    $display("reissue: result=%h lat=%0d valids=%0d", r, lat, nv);
    n_cmp++;
    if (nv !== 1) begin
      n_bad++;
      $display("FAIL reissue_valid_count: got %0d want 1", nv);
    end
    n_cmp++;
    if (r !== er || lat !== el) begin
      n_bad++;
      $display("FAIL reissue_result: got %h lat=%0d want %h lat=%0d", r, lat, er, el);
    end
    exp_hold = er;
  endtask

  task automatic test_sweep;
    int lanes_t [3];
    int pw_t    [3];
    int lat_o   [3];
    int nv_o    [3];
    logic [31:0] res_o [3];
    logic [31:0] w, p32, er;
    logic [7:0]  p8;
    logic        m;
    int q, el;
    lanes_t = '{1, 25, 1};
    pw_t    = '{8, 8, 32};
    for (int t = 0; t < 8; t++) begin
      w   = $urandom;
      p8  = 8'($urandom);
      m   = 1'(t % 2);
      if ((t % 4) < 2) begin
        q = $urandom_range(24, 0);
        w[q +: 8] = p8;
      end
      p32 = ((t % 4) == 0) ? w : $urandom;
      sw_word  = w;
      sw_pat8  = p8;
      sw_pat32 = p32;
      sw_mode  = m;
      sw_start = 1'b1;
      @(posedge clk); #1;
      sw_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
        lat_o[i] = -1;
        nv_o[i]  = 0;
        res_o[i] = 32'hDEAD_0BAD;
      end
      for (int c = 1; c <= 40; c++) begin
        for (int i = 0; i < 3; i++) begin
          if (sw_valid[i]) begin
            nv_o[i]++;
            if (lat_o[i] < 0) begin
              lat_o[i] = c;
              res_o[i] = sw_res[i];
            end
          end
        end
        @(posedge clk); #1;
      end
      for (int i = 0; i < 3; i++) begin
        ref_model(w, (i == 2) ? p32 : {24'd0, p8}, pw_t[i], lanes_t[i], m, er, el);
        $display("sweep %0d inst %0d: lanes=%0d pat_w=%0d mode=%b result=%h lat=%0d",
                 t, i, lanes_t[i], pw_t[i], m, res_o[i], lat_o[i]);
        n_cmp++;
        if (res_o[i] !== er || lat_o[i] !== el || nv_o[i] !== 1) begin
          n_bad++;
          $display("FAIL sweep[%0d][%0d]: got %h lat=%0d valids=%0d want %h lat=%0d valids=1",
                   t, i, res_o[i], lat_o[i], nv_o[i], er, el);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_async_reset();
    test_back_to_back();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
